// File: rtl/floo_axi_perf_monitor.sv
// Passive multi-port AXI performance monitor.
// Per port it tracks live outstanding AR/AW transactions and their peaks.
// It also counts R/W data beats over fixed windows and publishes per-window snapshots.
// The monitor only snoops the buses, so it never drives or stalls them.

package floo_axi_perf_pkg;

   // Minimal default channel types holding only the fields the monitor observes.
   // Real benches override req_t/rsp_t with their full AXI structs.
   typedef struct packed {
      logic last;
   } r_chan_t;

   typedef struct packed {
      logic ar_valid;
      logic aw_valid;
      logic w_valid;
      logic r_ready;
      logic b_ready;
   } axi_req_t;

   typedef struct packed {
      logic    ar_ready;
      logic    aw_ready;
      logic    w_ready;
      logic    r_valid;
      r_chan_t r;
      logic    b_valid;
   } axi_rsp_t;

endpackage

module floo_axi_perf_monitor #(
   parameter int unsigned NumPorts      = 2,
   parameter int unsigned CntWidth      = 32,
   parameter int unsigned InFlightWidth = 16,
   parameter int unsigned WindowCycles  = 1024,
   parameter type         req_t         = floo_axi_perf_pkg::axi_req_t,
   parameter type         rsp_t         = floo_axi_perf_pkg::axi_rsp_t
) (
   input  logic                                    clk_i,
   input  logic                                    rst_ni,
   input  logic                                    en_i,
   input  logic                                    clr_i,
   input  req_t [NumPorts-1:0]                     req_i,
   input  rsp_t [NumPorts-1:0]                     rsp_i,
   output logic [NumPorts-1:0][InFlightWidth-1:0]  ar_in_flight_o,
   output logic [NumPorts-1:0][InFlightWidth-1:0]  aw_in_flight_o,
   output logic [NumPorts-1:0][InFlightWidth-1:0]  ar_peak_o,
   output logic [NumPorts-1:0][InFlightWidth-1:0]  aw_peak_o,
   output logic [NumPorts-1:0][CntWidth-1:0]       r_beats_o,
   output logic [NumPorts-1:0][CntWidth-1:0]       w_beats_o,
   output logic                                    win_valid_o,
   output logic [CntWidth-1:0]                     win_idx_o,
   output logic [NumPorts-1:0]                     err_o
);

   localparam int unsigned WinW = (WindowCycles > 1) ? $clog2(WindowCycles) : 1;
   localparam logic [WinW-1:0]          WinLast = WinW'(WindowCycles - 1);
   localparam logic [WinW-1:0]          WinOne  = 1;
   localparam logic [InFlightWidth-1:0] IfOne   = 1;
   localparam logic [CntWidth-1:0]      CntOne  = 1;

   logic [WinW-1:0]     win_cnt_q;
   logic                win_valid_q;
   logic [CntWidth-1:0] win_idx_q;
   logic                rollover;

   // Returns {error, next count}.
   // Simultaneous increment and decrement cancel out.
   // Overflow or underflow holds the count and flags an error.
   function automatic logic [InFlightWidth:0] step_in_flight(
      input logic [InFlightWidth-1:0] cnt,
      input logic                     inc,
      input logic                     dec
   );
      logic [InFlightWidth-1:0] nxt;
      logic                     err;
      nxt = cnt;
      err = 1'b0;
      if (inc && !dec) begin
         if (&cnt) err = 1'b1;
         else      nxt = cnt + IfOne;
      end else if (dec && !inc) begin
         if (cnt == '0) err = 1'b1;
         else           nxt = cnt - IfOne;
      end
      return {err, nxt};
   endfunction

   // Beat counters stick at all-ones instead of wrapping.
   function automatic logic [CntWidth-1:0] sat_inc(
      input logic [CntWidth-1:0] cnt,
      input logic                inc
   );
      return (inc && !(&cnt)) ? cnt + CntOne : cnt;
   endfunction

   // A window closes on the enabled edge that leaves the last window cycle.
   // A clear on that same edge suppresses the close.
   assign rollover = en_i & ~clr_i & (win_cnt_q == WinLast);

   // Window position, completed-window index and the one-cycle snapshot strobe.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         win_cnt_q   <= '0;
         win_valid_q <= 1'b0;
         win_idx_q   <= '0;
      end else if (clr_i) begin
         win_cnt_q   <= '0;
         win_valid_q <= 1'b0;
         win_idx_q   <= '0;
      end else begin
         win_valid_q <= rollover;
         if (en_i) begin
            if (rollover) begin
               win_cnt_q <= '0;
               win_idx_q <= win_idx_q + CntOne;
            end else begin
               win_cnt_q <= win_cnt_q + WinOne;
            end
         end
      end
   end

   assign win_valid_o = win_valid_q;
   assign win_idx_o   = win_idx_q;

   for (genvar p = 0; p < NumPorts; p++) begin : gen_port
      logic                     ar_hs, aw_hs, r_hs, r_last_hs, w_hs, b_hs;
      logic [InFlightWidth-1:0] ar_q, aw_q, ar_pk_q, aw_pk_q;
      logic [InFlightWidth:0]   ar_step, aw_step;
      logic [CntWidth-1:0]      r_live_q, w_live_q, r_snap_q, w_snap_q;
      logic [CntWidth-1:0]      r_sum, w_sum;
      logic                     err_q;

      assign ar_hs     = req_i[p].ar_valid & rsp_i[p].ar_ready;
      assign aw_hs     = req_i[p].aw_valid & rsp_i[p].aw_ready;
      assign r_hs      = rsp_i[p].r_valid  & req_i[p].r_ready;
      assign r_last_hs = r_hs & rsp_i[p].r.last;
      assign w_hs      = req_i[p].w_valid  & rsp_i[p].w_ready;
      assign b_hs      = rsp_i[p].b_valid  & req_i[p].b_ready;

      assign ar_step = step_in_flight(ar_q, ar_hs, r_last_hs);
      assign aw_step = step_in_flight(aw_q, aw_hs, b_hs);
      assign r_sum   = sat_inc(r_live_q, r_hs);
      assign w_sum   = sat_inc(w_live_q, w_hs);

      // In-flight counts, their running maxima and the sticky protocol error.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            ar_q    <= '0;
            aw_q    <= '0;
            ar_pk_q <= '0;
            aw_pk_q <= '0;
            err_q   <= 1'b0;
         end else if (clr_i) begin
            ar_q    <= '0;
            aw_q    <= '0;
            ar_pk_q <= '0;
            aw_pk_q <= '0;
            err_q   <= 1'b0;
         end else if (en_i) begin
            ar_q  <= ar_step[InFlightWidth-1:0];
            aw_q  <= aw_step[InFlightWidth-1:0];
            err_q <= err_q | ar_step[InFlightWidth] | aw_step[InFlightWidth];
            if (ar_step[InFlightWidth-1:0] > ar_pk_q) ar_pk_q <= ar_step[InFlightWidth-1:0];
            if (aw_step[InFlightWidth-1:0] > aw_pk_q) aw_pk_q <= aw_step[InFlightWidth-1:0];
         end
      end

      // Live beat accumulation.
      // The beat in the closing cycle is folded into the snapshot.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_live_q <= '0;
            w_live_q <= '0;
            r_snap_q <= '0;
            w_snap_q <= '0;
         end else if (clr_i) begin
            r_live_q <= '0;
            w_live_q <= '0;
            r_snap_q <= '0;
            w_snap_q <= '0;
         end else if (en_i) begin
            if (rollover) begin
               r_snap_q <= r_sum;
               w_snap_q <= w_sum;
               r_live_q <= '0;
               w_live_q <= '0;
            end else begin
               r_live_q <= r_sum;
               w_live_q <= w_sum;
            end
         end
      end

      assign ar_in_flight_o[p] = ar_q;
      assign aw_in_flight_o[p] = aw_q;
      assign ar_peak_o[p]      = ar_pk_q;
      assign aw_peak_o[p]      = aw_pk_q;
      assign r_beats_o[p]      = r_snap_q;
      assign w_beats_o[p]      = w_snap_q;
      assign err_o[p]          = err_q;
   end

endmodule

// File: tb/tb_floo_axi_perf_monitor.sv
// Randomised and directed bench for floo_axi_perf_monitor.
// A behavioural model tracks counts and windows using plain integers.
module tb_floo_axi_perf_monitor;
   import floo_axi_perf_pkg::*;

   localparam int NP   = 2;
   localparam int CW   = 8;
   localparam int IFW  = 3;
   localparam int W    = 16;
   localparam int MAXF = (1 << IFW) - 1;
   localparam int MAXC = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst_n, en, clr;
   axi_req_t [NP-1:0] req;
   axi_rsp_t [NP-1:0] rsp;

   logic [NP-1:0][IFW-1:0] ar_in_flight, aw_in_flight, ar_peak, aw_peak;
   logic [NP-1:0][CW-1:0]  r_beats, w_beats;
   logic                   win_valid;
   logic [CW-1:0]          win_idx;
   logic [NP-1:0]          err;

   bit ar_v[NP], ar_r[NP], aw_v[NP], aw_r[NP], w_v[NP], w_r[NP];
   bit r_v[NP], r_r[NP], r_l[NP], b_v[NP], b_r[NP];

   int m_arf[NP], m_awf[NP], m_arpk[NP], m_awpk[NP];
   int m_live_r[NP], m_live_w[NP], m_snap_r[NP], m_snap_w[NP];
   int m_err[NP];
   int m_valid, m_idx, m_en_cycles;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   floo_axi_perf_monitor #(
      .NumPorts(NP), .CntWidth(CW), .InFlightWidth(IFW), .WindowCycles(W),
      .req_t(axi_req_t), .rsp_t(axi_rsp_t)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr),
      .req_i(req), .rsp_i(rsp),
      .ar_in_flight_o(ar_in_flight), .aw_in_flight_o(aw_in_flight),
      .ar_peak_o(ar_peak), .aw_peak_o(aw_peak),
      .r_beats_o(r_beats), .w_beats_o(w_beats),
      .win_valid_o(win_valid), .win_idx_o(win_idx), .err_o(err)
   );

   // Single comparison point; every check is counted here.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic clearInputs();
      for (int p = 0; p < NP; p++) begin
         ar_v[p] = 0; ar_r[p] = 0; aw_v[p] = 0; aw_r[p] = 0; w_v[p] = 0; w_r[p] = 0;
         r_v[p] = 0; r_r[p] = 0; r_l[p] = 0; b_v[p] = 0; b_r[p] = 0;
      end
   endtask

   task automatic randomInputs(input int pct);
      for (int p = 0; p < NP; p++) begin
         ar_v[p] = ($urandom_range(0, 99) < pct); ar_r[p] = ($urandom_range(0, 99) < pct);
         aw_v[p] = ($urandom_range(0, 99) < pct); aw_r[p] = ($urandom_range(0, 99) < pct);
         w_v[p]  = ($urandom_range(0, 99) < pct); w_r[p]  = ($urandom_range(0, 99) < pct);
         r_v[p]  = ($urandom_range(0, 99) < pct); r_r[p]  = ($urandom_range(0, 99) < pct);
         r_l[p]  = ($urandom_range(0, 99) < 40);
         b_v[p]  = ($urandom_range(0, 99) < pct); b_r[p]  = ($urandom_range(0, 99) < pct);
      end
   endtask

   task automatic drivePins();
      for (int p = 0; p < NP; p++) begin
         req[p].ar_valid = ar_v[p]; req[p].aw_valid = aw_v[p]; req[p].w_valid = w_v[p];
         req[p].r_ready  = r_r[p];  req[p].b_ready  = b_r[p];
         rsp[p].ar_ready = ar_r[p]; rsp[p].aw_ready = aw_r[p]; rsp[p].w_ready = w_r[p];
         rsp[p].r_valid  = r_v[p];  rsp[p].r.last   = r_l[p];  rsp[p].b_valid = b_v[p];
      end
   endtask

   task automatic modelReset();
      for (int p = 0; p < NP; p++) begin
         m_arf[p] = 0; m_awf[p] = 0; m_arpk[p] = 0; m_awpk[p] = 0;
         m_live_r[p] = 0; m_live_w[p] = 0; m_snap_r[p] = 0; m_snap_w[p] = 0; m_err[p] = 0;
      end
      m_valid = 0; m_idx = 0; m_en_cycles = 0;
   endtask

   // Behaviour of one clock edge, expressed as integer bookkeeping.
   task automatic modelEdge();
      if (!rst_n || clr) begin
         modelReset();
      end else if (!en) begin
         m_valid = 0;
      end else begin
         for (int p = 0; p < NP; p++) begin
            int rd_delta;
            int wr_delta;
            rd_delta = int'(ar_v[p] & ar_r[p]) - int'(r_v[p] & r_r[p] & r_l[p]);
            wr_delta = int'(aw_v[p] & aw_r[p]) - int'(b_v[p] & b_r[p]);
            if (m_arf[p] + rd_delta > MAXF || m_arf[p] + rd_delta < 0) m_err[p] = 1;
            else m_arf[p] = m_arf[p] + rd_delta;
            if (m_awf[p] + wr_delta > MAXF || m_awf[p] + wr_delta < 0) m_err[p] = 1;
            else m_awf[p] = m_awf[p] + wr_delta;
            if (m_arf[p] > m_arpk[p]) m_arpk[p] = m_arf[p];
            if (m_awf[p] > m_awpk[p]) m_awpk[p] = m_awf[p];
            if (r_v[p] && r_r[p] && m_live_r[p] < MAXC) m_live_r[p]++;
            if (w_v[p] && w_r[p] && m_live_w[p] < MAXC) m_live_w[p]++;
         end
         m_en_cycles++;
         if (m_en_cycles == W) begin
            for (int p = 0; p < NP; p++) begin
               m_snap_r[p] = m_live_r[p]; m_snap_w[p] = m_live_w[p];
               m_live_r[p] = 0; m_live_w[p] = 0;
            end
            m_valid = 1;
            m_idx = (m_idx + 1) % (1 << CW);
            m_en_cycles = 0;
         end else begin
            m_valid = 0;
         end
      end
   endtask

   task automatic compareAll();
      logic [NP*IFW-1:0] e_arf, e_awf, e_arpk, e_awpk;
      logic [NP*CW-1:0]  e_rb, e_wb;
      logic [NP-1:0]     e_err;
      for (int p = 0; p < NP; p++) begin
         e_arf[p*IFW +: IFW]  = m_arf[p][IFW-1:0];
         e_awf[p*IFW +: IFW]  = m_awf[p][IFW-1:0];
         e_arpk[p*IFW +: IFW] = m_arpk[p][IFW-1:0];
         e_awpk[p*IFW +: IFW] = m_awpk[p][IFW-1:0];
         e_rb[p*CW +: CW]     = m_snap_r[p][CW-1:0];
         e_wb[p*CW +: CW]     = m_snap_w[p][CW-1:0];
         e_err[p]             = m_err[p][0];
      end
      checkOutput("ar_in_flight", 64'(ar_in_flight), 64'(e_arf));
      checkOutput("aw_in_flight", 64'(aw_in_flight), 64'(e_awf));
      checkOutput("ar_peak", 64'(ar_peak), 64'(e_arpk));
      checkOutput("aw_peak", 64'(aw_peak), 64'(e_awpk));
      checkOutput("r_beats", 64'(r_beats), 64'(e_rb));
      checkOutput("w_beats", 64'(w_beats), 64'(e_wb));
      checkOutput("win_valid", 64'(win_valid), 64'(m_valid[0]));
      checkOutput("win_idx", 64'(win_idx), 64'(m_idx[CW-1:0]));
      checkOutput("err", 64'(err), 64'(e_err));
   endtask

   // One cycle: drive on the falling edge, step the model on the rising edge, sample just after.
   task automatic applyStimulus();
      @(negedge clk);
      drivePins();
      @(posedge clk);
      modelEdge();
      #1 compareAll();
   endtask

   task automatic idleUntil(input int pos, input string tag);
      int guard;
      guard = 0;
      clearInputs();
      while (m_en_cycles != pos && guard < 4 * W) begin
         applyStimulus();
         guard++;
      end
      checkOutput(tag, 64'(m_en_cycles), 64'(pos));
   endtask

   initial begin
      int first;
      rst_n = 0; en = 0; clr = 0;
      clearInputs(); drivePins(); modelReset();

      // AR handshakes presented while reset is held must leave no trace.
      en = 1; ar_v[0] = 1; ar_r[0] = 1;
      repeat (3) applyStimulus();
      rst_n = 1;
      clearInputs();

      // The first window after reset runs its full length.
      first = -1;
      for (int i = 1; i <= 3 * W && first < 0; i++) begin
         applyStimulus();
         if (win_valid) first = i;
      end
      checkOutput("first_win_cycle", 64'(first), 64'(W));

      // Four reads issued on port 0, then sixteen beats with last on every fourth.
      clearInputs(); ar_v[0] = 1; ar_r[0] = 1;
      repeat (4) applyStimulus();
      checkOutput("ar_peak_p0_four", 64'(ar_peak[0]), 64'd4);
      clearInputs(); r_v[0] = 1; r_r[0] = 1;
      for (int i = 0; i < 16; i++) begin
         r_l[0] = (i % 4 == 3);
         applyStimulus();
      end
      checkOutput("ar_if_p0_drained", 64'(ar_in_flight[0]), 64'd0);
      checkOutput("port1_peak_quiet", 64'(ar_peak[1]), 64'd0);

      // An AR and an R-last in the same cycle cancel out.
      clearInputs(); ar_v[0] = 1; ar_r[0] = 1;
      repeat (2) applyStimulus();
      r_v[0] = 1; r_r[0] = 1; r_l[0] = 1;
      applyStimulus();
      checkOutput("ar_if_p0_cancel", 64'(ar_in_flight[0]), 64'd2);
      checkOutput("err_after_cancel", 64'(err), 64'd0);
      clearInputs(); r_v[0] = 1; r_r[0] = 1; r_l[0] = 1;
      repeat (2) applyStimulus();

      // A B response with nothing outstanding is an error that sticks.
      clearInputs(); b_v[1] = 1; b_r[1] = 1;
      applyStimulus();
      checkOutput("err_p1_underflow", 64'(err[1]), 64'd1);
      clearInputs();
      repeat (3) applyStimulus();
      checkOutput("err_p1_sticky", 64'(err[1]), 64'd1);

      // A W beat in the closing cycle belongs to the closing window.
      idleUntil(0, "align_w_window");
      for (int i = 0; i < W; i++) begin
         clearInputs();
         if (i == 3 || i == 5 || i == 7 || i == 9 || i == 11 || i == W - 1) begin
            w_v[0] = 1; w_r[0] = 1;
         end
         applyStimulus();
      end
      checkOutput("w_beats_closing", 64'(w_beats[0]), 64'd6);
      for (int i = 0; i < W; i++) begin
         clearInputs();
         if (i == 0) begin
            w_v[0] = 1; w_r[0] = 1;
         end
         applyStimulus();
      end
      checkOutput("w_beats_next", 64'(w_beats[0]), 64'd1);

      // A clear in the rollover cycle wins over the window close.
      idleUntil(W - 1, "align_rollover");
      randomInputs(70);
      clr = 1;
      applyStimulus();
      clr = 0;
      checkOutput("clr_no_pulse", 64'(win_valid), 64'd0);
      checkOutput("clr_idx_zero", 64'(win_idx), 64'd0);

      // With counting disabled, handshakes are ignored and nothing advances.
      en = 0;
      for (int i = 0; i < 10; i++) begin
         randomInputs(70);
         applyStimulus();
      end
      checkOutput("disabled_idx_hold", 64'(win_idx), 64'd0);
      en = 1;

      // Random traffic with occasional disable, clear and a mid-window reset.
      for (int i = 0; i < 3000; i++) begin
         randomInputs((i < 1500) ? 60 : 45);
         en  = ($urandom_range(0, 99) < 95);
         clr = ($urandom_range(0, 999) < 3);
         if (i == 1500) begin
            rst_n = 0;
            modelReset();
            #1 compareAll();
            applyStimulus();
            rst_n = 1;
         end
         applyStimulus();
      end
      clr = 0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Watchdog to guarantee the run ends on its own.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
